// File: rtl/gauss_window_filter.sv
// rtl/gauss_window_filter.sv - applies a latched Gaussian kernel to one pixel window
// using a serial MAC and a rounding restoring divider, emitting one 8-bit pixel.
module gauss_window_filter #(
    parameter int MAX_KERNEL = 7,
    localparam int KS_W  = $clog2(MAX_KERNEL),
    localparam int ACC_W = 16 + $clog2(MAX_KERNEL * MAX_KERNEL),
    localparam int DIV_W = ACC_W + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               kernel_load,
    input  logic [MAX_KERNEL*MAX_KERNEL*8-1:0] kernel,
    input  logic [31:0]                        kernel_sum,
    input  logic [KS_W-1:0]                    kernel_size,
    input  logic                               win_valid,
    output logic                               win_ready,
    input  logic [MAX_KERNEL*MAX_KERNEL*8-1:0] window,
    output logic [7:0]                         pix_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               kernel_loaded
);
    localparam int NT = MAX_KERNEL * MAX_KERNEL;
    localparam int KW = NT * 8;
    localparam int IW = $clog2(NT);
    localparam int CW = $clog2(DIV_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]      state;
    logic [KW-1:0]   sh_kernel, act_kernel, win_reg;
    logic [31:0]     sh_sum, act_sum;
    logic [KS_W-1:0] sh_size, ks_last, x, y;
    logic [ACC_W-1:0] acc;
    logic [DIV_W-1:0] dvd;
    logic [32:0]     rem;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic [KS_W-1:0] sel_size, eff_size;
    logic [IW-1:0]   tap_idx;
    logic [IW+2:0]   tap_bit;
    logic [15:0]     tap_prod;
    logic [ACC_W-1:0] acc_next;
    logic [DIV_W-1:0] dividend;
    logic [33:0]     rem_sh;
    logic            sub_ok;
    logic [32:0]     rem_nx;
    logic [DIV_W-1:0] dvd_nx;
    logic [7:0]      q_sat;

    assign win_ready = (state == S_IDLE) && kernel_loaded;
    assign accept    = win_valid && win_ready;

    // A load coinciding with accept bypasses the shadow registers.
    assign sel_size = kernel_load ? kernel_size : sh_size;
    assign eff_size = (sel_size == '0) ? KS_W'(1) : sel_size;

    assign tap_idx  = IW'(x) * IW'(MAX_KERNEL) + IW'(y);
    assign tap_bit  = {tap_idx, 3'b000};
    assign tap_prod = act_kernel[tap_bit +: 8] * win_reg[tap_bit +: 8];
    assign acc_next = acc + ACC_W'(tap_prod);
    assign dividend = {1'b0, acc_next} + act_sum[DIV_W:1];

    // Restoring divide step; the dividend register shifts out MSB-first and
    // fills with quotient bits, so it holds the quotient after DIV_W steps.
    assign rem_sh = {rem, dvd[DIV_W-1]};
    assign sub_ok = rem_sh >= {2'b00, act_sum};
    assign rem_nx = sub_ok ? 33'(rem_sh - {2'b00, act_sum}) : rem_sh[32:0];
    assign dvd_nx = {dvd[DIV_W-2:0], sub_ok};
    assign q_sat  = (|dvd_nx[DIV_W-1:8]) ? 8'hFF : dvd_nx[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            sh_kernel     <= '0;
            sh_sum        <= '0;
            sh_size       <= '0;
            act_kernel    <= '0;
            act_sum       <= '0;
            ks_last       <= '0;
            win_reg       <= '0;
            x             <= '0;
            y             <= '0;
            acc           <= '0;
            dvd           <= '0;
            rem           <= '0;
            cnt           <= '0;
            pix_out       <= '0;
            out_valid     <= 1'b0;
            kernel_loaded <= 1'b0;
        end else begin
            if (kernel_load) begin
                sh_kernel     <= kernel;
                sh_sum        <= kernel_sum;
                sh_size       <= kernel_size;
                kernel_loaded <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        win_reg    <= window;
                        act_kernel <= kernel_load ? kernel : sh_kernel;
                        act_sum    <= kernel_load ? kernel_sum : sh_sum;
                        ks_last    <= eff_size - KS_W'(1);
                        acc        <= '0;
                        x          <= '0;
                        y          <= '0;
                        state      <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (y == ks_last) begin
                        y <= '0;
                        if (x == ks_last) begin
                            dvd   <= dividend;
                            rem   <= '0;
                            cnt   <= '0;
                            state <= S_DIV;
                        end else begin
                            x <= x + KS_W'(1);
                        end
                    end else begin
                        y <= y + KS_W'(1);
                    end
                end
                S_DIV: begin
                    if (act_sum != '0) begin
                        rem <= rem_nx;
                        dvd <= dvd_nx;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DIV_W - 1)) begin
                        pix_out   <= (act_sum == '0) ? 8'd0 : q_sat;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gauss_window_filter.sv
// tb/tb_gauss_window_filter.sv - self-checking bench for gauss_window_filter
module tb_gauss_window_filter;
    localparam int MK = 7;
    localparam int KW = MK * MK * 8;
    localparam int DIV_W = 23;

    logic          clk = 1'b0;
    logic          rst, kernel_load, win_valid, out_ready;
    logic [KW-1:0] kernel, window;
    logic [31:0]   kernel_sum;
    logic [2:0]    kernel_size;
    logic          win_ready, out_valid, kernel_loaded;
    logic [7:0]    pix_out;

    gauss_window_filter #(.MAX_KERNEL(MK)) dut (
        .clk(clk), .rst(rst), .kernel_load(kernel_load), .kernel(kernel),
        .kernel_sum(kernel_sum), .kernel_size(kernel_size), .win_valid(win_valid),
        .win_ready(win_ready), .window(window), .pix_out(pix_out),
        .out_valid(out_valid), .out_ready(out_ready), .kernel_loaded(kernel_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int pix; int lat; int acc_cyc;} exp_t;
    exp_t exp_q[$];

    logic [KW-1:0] m_k;
    logic [31:0]   m_sum;
    logic [2:0]    m_size;
    bit            bp_rand = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int model_pix(input logic [KW-1:0] k, input logic [KW-1:0] w,
                                     input logic [31:0] s, input logic [2:0] sz);
        int ks;
        longint acc;
        longint q;
        ks  = (sz == 0) ? 1 : int'(sz);
        acc = 0;
        for (int xx = 0; xx < ks; xx++)
            for (int yy = 0; yy < ks; yy++)
                acc += longint'(k[(xx*MK+yy)*8 +: 8]) * longint'(w[(xx*MK+yy)*8 +: 8]);
        if (s == 0) return 0;
        q = (acc + longint'(s >> 1)) / longint'(s);
        return (q > 255) ? 255 : int'(q);
    endfunction

    function automatic int model_lat(input logic [2:0] sz);
        int ks;
        ks = (sz == 0) ? 1 : int'(sz);
        return ks * ks + DIV_W;
    endfunction

    function automatic logic [31:0] true_sum(input logic [KW-1:0] k, input logic [2:0] sz);
        int ks;
        logic [31:0] s;
        ks = (sz == 0) ? 1 : int'(sz);
        s = 0;
        for (int xx = 0; xx < ks; xx++)
            for (int yy = 0; yy < ks; yy++)
                s += 32'(k[(xx*MK+yy)*8 +: 8]);
        return s;
    endfunction

    function automatic logic [KW-1:0] rand_vec();
        logic [KW-1:0] v;
        for (int i = 0; i < MK*MK; i++) v[i*8 +: 8] = 8'($urandom);
        return v;
    endfunction

    function automatic logic [KW-1:0] fill(input logic [7:0] b);
        logic [KW-1:0] v;
        for (int i = 0; i < MK*MK; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    // Compare process: checks every output beat against the queued expectation.
    initial begin
        bit ov_prev;
        logic [7:0] pix_prev;
        ov_prev = 1'b0;
        pix_prev = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("stray_out_valid", 1, 0);
                    end else if (!ov_prev) begin
                        chk("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                        chk("pix_out", pix_out, exp_q[0].pix);
                    end else begin
                        chk("pix_hold", pix_out, pix_prev);
                    end
                    chk("win_ready_in_out", win_ready, 0);
                    if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                end
                ov_prev  = out_valid && !out_ready;
                pix_prev = pix_out;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = ($urandom % 3) != 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_kernel_loaded", kernel_loaded, 0);
        chk("rst_win_ready", win_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input logic [KW-1:0] k, input logic [31:0] s, input logic [2:0] sz);
        kernel = k;
        kernel_sum = s;
        kernel_size = sz;
        kernel_load = 1'b1;
        step(1);
        kernel_load = 1'b0;
        m_k = k;
        m_sum = s;
        m_size = sz;
    endtask

    // Present a window; if kernel_load is already high the presented kernel is the one used.
    task automatic send(input logic [KW-1:0] w);
        bit got;
        exp_t e;
        got = 1'b0;
        window = w;
        win_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = win_ready;
        end
        if (!got) begin
            chk("accept_timeout", 1, 0);
            win_valid = 1'b0;
            kernel_load = 1'b0;
            step(1);
            return;
        end
        if (kernel_load) begin
            e.pix = model_pix(kernel, w, kernel_sum, kernel_size);
            e.lat = model_lat(kernel_size);
        end else begin
            e.pix = model_pix(m_k, w, m_sum, m_size);
            e.lat = model_lat(m_size);
        end
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (kernel_load) begin
            m_k = kernel;
            m_sum = kernel_sum;
            m_size = kernel_size;
            kernel_load = 1'b0;
        end
        win_valid = 1'b0;
        window = rand_vec();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        step(1);
    endtask

    initial begin
        logic [KW-1:0] k, w;
        logic [31:0] s;
        logic [2:0] sz;
        bit seen;
        rst = 1'b1; kernel_load = 1'b0; win_valid = 1'b0; out_ready = 1'b1;
        kernel = '0; window = '0; kernel_sum = '0; kernel_size = '0;
        m_k = '0; m_sum = '0; m_size = '0;
        step(1);
        do_reset();

        // No kernel yet: window must stall.
        win_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_win_ready", win_ready, 0);
        end
        step(1);
        win_valid = 1'b0;

        // ks=1 identity-like
        k = '0; k[7:0] = 8'd100;
        w = rand_vec(); w[7:0] = 8'd200;
        chk("model_t1", model_pix(k, w, 100, 1), 200);
        load(k, 100, 1);
        chk("kernel_loaded_set", kernel_loaded, 1);
        send(w); wait_done();

        // ks=3 box
        k = fill(8'd10); w = rand_vec();
        for (int xx = 0; xx < 3; xx++) for (int yy = 0; yy < 3; yy++) w[(xx*MK+yy)*8 +: 8] = 8'd50;
        chk("model_t2", model_pix(k, w, 90, 3), 50);
        load(k, 90, 3); send(w); wait_done();

        // ks=3 centre tap only
        k = '0; k[(1*MK+1)*8 +: 8] = 8'd100;
        w = fill(8'd255); w[(1*MK+1)*8 +: 8] = 8'd77;
        chk("model_t3", model_pix(k, w, 100, 3), 77);
        load(k, 100, 3); send(w); wait_done();

        // saturation
        k = '0; k[7:0] = 8'd100; w = '0; w[7:0] = 8'd200;
        chk("model_sat", model_pix(k, w, 50, 1), 255);
        load(k, 50, 1); send(w); wait_done();

        // zero sum
        k = rand_vec(); w = rand_vec();
        chk("model_zero", model_pix(k, w, 0, 3), 0);
        load(k, 0, 3); send(w); wait_done();

        // rounding
        k = '0; k[7:0] = 8'd3; w = '0; w[7:0] = 8'd1;
        chk("model_round1", model_pix(k, w, 2, 1), 2);
        load(k, 2, 1); send(w); wait_done();
        w[7:0] = 8'd0;
        chk("model_round0", model_pix(k, w, 2, 1), 0);
        send(w); wait_done();

        // backpressure
        k = rand_vec(); load(k, true_sum(k, 2), 2);
        out_ready = 1'b0;
        send(rand_vec());
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("bp_valid_seen", seen, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_win_ready", win_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done();

        // kernel_load mid-MAC does not disturb in-flight result
        k = rand_vec(); load(k, true_sum(k, 3), 3);
        send(rand_vec());
        step(3);
        k = rand_vec(); load(k, true_sum(k, 4), 4);
        wait_done();
        send(rand_vec()); wait_done();

        // bypass: load and accept on the same edge
        k = rand_vec();
        kernel = k; kernel_sum = true_sum(k, 5); kernel_size = 3'd5; kernel_load = 1'b1;
        send(rand_vec()); wait_done();

        // reset mid-DIV
        k = rand_vec(); load(k, true_sum(k, 3), 3);
        send(rand_vec());
        step(14);
        do_reset();
        repeat (30) begin
            @(negedge clk);
            chk("no_stale_out_valid", out_valid, 0);
        end
        chk("post_rst_loaded", kernel_loaded, 0);
        step(1);

        // randomized traffic
        bp_rand = 1'b1;
        k = rand_vec(); load(k, true_sum(k, 3), 3);
        for (int it = 0; it < 40; it++) begin
            k  = rand_vec();
            sz = 3'($urandom % 8);
            case ($urandom % 10)
                0:       s = 0;
                1, 2:    s = 32'($urandom_range(1, 3000));
                default: s = true_sum(k, sz);
            endcase
            if ($urandom % 4 == 0) begin
                kernel = k; kernel_sum = s; kernel_size = sz; kernel_load = 1'b1;
            end else if ($urandom % 2 == 0) begin
                load(k, s, sz);
            end
            send(rand_vec());
            if ($urandom % 2 == 0) begin
                step($urandom_range(0, 40));
                k = rand_vec(); sz = 3'($urandom % 8);
                load(k, true_sum(k, sz), sz);
            end
            wait_done();
        end
        bp_rand = 1'b0;
        out_ready = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gauss_window_filter.md
Name: gauss_window_filter

Overview:
- Downstream consumer of the Gaussian kernel generator. Latches the generated kernel, its coefficient sum and its size.
- Applies the kernel to one pixel window per transaction using a serial multiply-accumulate, one tap per cycle.
- Normalises the result by the kernel sum with a sequential rounding divider and emits one 8-bit blurred pixel.
- Feeds the FAST corner stage.

Parameters:
- MAX_KERNEL, 7, maximum kernel/window edge length.
- KS_W, $clog2(MAX_KERNEL), width of kernel_size (localparam).
- ACC_W, 16+$clog2(MAX_KERNEL*MAX_KERNEL), accumulator width (localparam, 22 at default).
- DIV_W, ACC_W+1, dividend width and divider iteration count (localparam, 23 at default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- kernel_load  in  1  one-cycle pulse; capture kernel, kernel_sum, kernel_size into shadow registers.
- kernel  in  MAX_KERNEL*MAX_KERNEL*8  coefficient (x,y) at bits [(x*MAX_KERNEL+y)*8 +: 8], unsigned.
- kernel_sum  in  32  sum of all coefficients, unsigned.
- kernel_size  in  KS_W  active edge length.
- win_valid  in  1  window present.
- win_ready  out  1  block can accept a window.
- window  in  MAX_KERNEL*MAX_KERNEL*8  pixel (x,y), same packing as kernel.
- pix_out  out  8  normalised filtered pixel.
- out_valid  out  1  pix_out valid.
- out_ready  in  1  consumer accepts pix_out.
- kernel_loaded  out  1  at least one kernel captured since reset.

Behaviour:
- Reset (rst high at a clk edge): state IDLE; win_ready=0, out_valid=0, pix_out=0, kernel_loaded=0; all shadow, active, accumulator and divider registers cleared. Reset takes effect mid-transaction; any in-flight result is discarded and no out_valid is produced for it.
- Shadow capture: kernel_load is honoured in every state and overwrites the shadow registers. kernel_loaded sets on the first load.
- Effective size: ks = (kernel_size==0) ? 1 : kernel_size. Even sizes are legal; taps run from x,y = 0..ks-1.
- Handshake: accept occurs at an edge where win_valid && win_ready.
  - At accept, the window is captured and the shadow registers are copied to the active registers.
  - If kernel_load and accept fall on the same edge, the newly presented kernel inputs are used (bypass).
  - A kernel_load after accept never affects the in-flight transaction.
- IDLE:
  - win_ready = kernel_loaded.
  - On accept: acc=0, x=y=0, go to MAC.
- MAC (ks*ks cycles, win_ready=0):
  - Each cycle, acc += window(x,y)*kernel(x,y) as an 8x8 unsigned product into ACC_W bits (never overflows).
  - y is the inner index, x the outer.
  - After tap (ks-1,ks-1), go to DIV.
- DIV (DIV_W cycles): restoring divide.
  - Dividend = acc + (kernel_sum>>1); divisor = kernel_sum.
  - One quotient bit per cycle, MSB first. Remainder register is 33 bits.
  - After DIV_W cycles: q = floor(dividend/kernel_sum); pix_out = (q>255) ? 255 : q[7:0].
  - If kernel_sum==0, pix_out=0 and the divide is skipped; DIV still lasts DIV_W cycles so latency is constant.
  - Go to OUT.
- OUT:
  - out_valid=1; pix_out held stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0 at the next edge and the state returns to IDLE.
  - No new window is accepted in OUT; there is no output pipelining.
- Latency: out_valid first high ks*ks + DIV_W edges after the accept edge. Throughput is one window per ks*ks+DIV_W+2 cycles at best.
- win_valid without kernel_loaded: stalls with win_ready=0; no error.

Test Plan:
- Reset, load ks=1, kernel(0,0)=100, sum=100; window(0,0)=200 -> pix_out=200, out_valid exactly 24 edges after accept (default params).
- ks=3, all nine coefficients 10, sum=90; all pixels 50 -> pix_out=50; out_valid 32 edges after accept.
- ks=3, only center coefficient 100, sum=100; center pixel 77, others 255 -> pix_out=77. Then ks=1, coeff 100, sum=50, pixel 200 -> 400 saturates to pix_out=255.
- kernel_sum=0, ks=3, any window -> pix_out=0, constant latency.
- Rounding: ks=1, coeff 3, sum=2, pixel 1.
  - dividend 3+1=4, 4/2=2 -> pix_out=2.
  - pixel 0 -> dividend 1, 1/2=0 -> pix_out=0.
- Backpressure and interference:
  - out_ready low 5 cycles -> pix_out stable, win_ready=0 throughout.
  - kernel_load (new coefficients) mid-MAC -> current result unchanged, next window uses new kernel.
  - rst asserted mid-DIV -> all outputs 0 next edge, no stale out_valid, kernel_loaded=0.
